// File: rtl/sgd_seq_ctrl.sv
// sgd_seq_ctrl: load -> train -> hold run sequencer for the serial-load / RAM /
// SGD linear-regression datapath. It owns the sub-block resets and enables,
// muxes the RAM address, counts RAM writes against the requested row count,
// and reports configuration / length errors.
// Build option: define SEQ_TIMEOUT_EN to include the progress watchdog
// (TIMEOUT_W-bit idle counter in LOAD/TRAIN, fault code 3 on expiry).
module sgd_seq_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int FEAT_W    = 4,
  parameter int EPOCH_W   = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  data_points,
  input  logic [FEAT_W-1:0]  feat,
  input  logic [EPOCH_W-1:0] epoch,
  input  logic               ser_flag,
  input  logic               ser_done,
  input  logic [ADDR_W-1:0]  ser_addr,
  input  logic               sgd_done,
  input  logic [ADDR_W-1:0]  sgd_addr,
  output logic               ser_rst,
  output logic               ram_rst,
  output logic               sgd_rst,
  output logic               ram_we,
  output logic               ram_oe,
  output logic               sgd_hold,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [2:0]         state,
  output logic [ADDR_W-1:0]  wr_cnt,
  output logic [7:0]         run_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_LOAD  = 3'd2,
    S_TRAIN = 3'd3,
    S_HOLD  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_CFG  = 2'd1;
  localparam logic [1:0] E_LEN  = 2'd2;
  localparam logic [1:0] E_TMO  = 2'd3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          w_fault_code;
  logic [1:0]          r_err_code;
  logic [ADDR_W-1:0]   r_dp;
  logic [FEAT_W-1:0]   r_feat;
  logic [EPOCH_W-1:0]  r_epoch;
  logic [ADDR_W-1:0]   r_wr_cnt;
  logic [7:0]          r_run_cnt;
  logic                w_we;
  logic                w_wd_hit;
  logic                w_prime_entry;
  logic [ADDR_W-1:0]   w_wr_total;

  // A RAM write happens only for a valid serial word while rows remain.
  assign w_we = (r_state == S_LOAD) && !ser_flag && !ser_done && (r_wr_cnt < r_dp);

  // Row count including this cycle's write, used for the ser_done length check.
  assign w_wr_total = r_wr_cnt + ADDR_W'(w_we);

  // PRIME never repeats, so any transition into it is a fresh run.
  assign w_prime_entry = (w_state_nxt == S_PRIME);

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 w_wd_run;

  assign w_wd_run = (r_state == S_LOAD) || (r_state == S_TRAIN);
  assign w_wd_hit = w_wd_run && (r_wd == '1);

  // Watchdog: restarts on any state change and on every RAM write, counts idle LOAD/TRAIN cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wd <= '0;
    end else if (w_prime_entry || w_we || (w_state_nxt != r_state)) begin
      r_wd <= '0;
    end else if (w_wd_run) begin
      r_wd <= r_wd + TIMEOUT_W'(1);
    end
  end
`else
  // No watchdog in this build; the parameter is kept so both builds share one port/parameter list.
  assign w_wd_hit = 1'b0 & (TIMEOUT_W > 0);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort outranks every normal transition in the active states.
  always_comb begin
    w_state_nxt  = r_state;
    w_fault_code = E_NONE;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if ((r_dp == '0) || (r_feat == '0) || (r_epoch == '0)) begin
          w_state_nxt  = S_FAULT;
          w_fault_code = E_CFG;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (ser_done) begin
          if (w_wr_total == r_dp) begin
            w_state_nxt = S_TRAIN;
          end else begin
            w_state_nxt  = S_FAULT;
            w_fault_code = E_LEN;
          end
        end else if (!ser_flag && (r_wr_cnt == r_dp)) begin
          w_state_nxt  = S_FAULT;
          w_fault_code = E_LEN;
        end else if (w_wd_hit) begin
          w_state_nxt  = S_FAULT;
          w_fault_code = E_TMO;
        end
      end
      S_TRAIN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (sgd_done) begin
          w_state_nxt = S_HOLD;
        end else if (w_wd_hit) begin
          w_state_nxt  = S_FAULT;
          w_fault_code = E_TMO;
        end
      end
      S_HOLD, S_FAULT: begin
        if (start) w_state_nxt = S_PRIME;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sub-block control and status decoded from the registered state; address mux follows the active master.
  always_comb begin
    ser_rst  = 1'b1;
    ram_rst  = 1'b1;
    sgd_rst  = 1'b1;
    ram_oe   = 1'b0;
    sgd_hold = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    ram_addr = '0;
    case (r_state)
      S_PRIME: begin
        busy = 1'b1;
      end
      S_LOAD: begin
        ser_rst  = 1'b0;
        ram_rst  = 1'b0;
        busy     = 1'b1;
        ram_addr = ser_addr;
      end
      S_TRAIN: begin
        ram_rst  = 1'b0;
        sgd_rst  = 1'b0;
        ram_oe   = 1'b1;
        busy     = 1'b1;
        ram_addr = sgd_addr;
      end
      S_HOLD: begin
        ram_rst  = 1'b0;
        sgd_rst  = 1'b0;
        ram_oe   = 1'b1;
        sgd_hold = 1'b1;
        done     = 1'b1;
        ram_addr = sgd_addr;
      end
      S_FAULT: begin
        ram_rst = 1'b0;
        error   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Run bookkeeping: write count and error code restart with each run, run count survives abort.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_code <= E_NONE;
      r_wr_cnt   <= '0;
      r_run_cnt  <= '0;
    end else begin
      if (w_prime_entry) begin
        r_err_code <= E_NONE;
        r_wr_cnt   <= '0;
      end else begin
        if (w_we) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
        if ((w_state_nxt == S_FAULT) && (r_state != S_FAULT)) r_err_code <= w_fault_code;
      end
      if ((r_state == S_TRAIN) && (w_state_nxt == S_HOLD)) r_run_cnt <= r_run_cnt + 8'd1;
    end
  end

  // Run configuration captured as PRIME is entered and held for the whole run.
  always_ff @(posedge CLK) begin
    if (w_prime_entry) begin
      r_dp    <= data_points;
      r_feat  <= feat;
      r_epoch <= epoch;
    end
  end

  assign ram_we   = w_we;
  assign state    = r_state;
  assign err_code = r_err_code;
  assign wr_cnt   = r_wr_cnt;
  assign run_cnt  = r_run_cnt;

endmodule

// File: tb/tb_sgd_seq_ctrl.sv
module tb_sgd_seq_ctrl;
  localparam int ADDR_W    = 12;
  localparam int FEAT_W    = 4;
  localparam int EPOCH_W   = 8;
  localparam int TIMEOUT_W = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [ADDR_W-1:0]  data_points = '0;
  logic [FEAT_W-1:0]  feat = '0;
  logic [EPOCH_W-1:0] epoch = '0;
  logic               ser_flag = 1'b1;
  logic               ser_done = 1'b0;
  logic [ADDR_W-1:0]  ser_addr = '0;
  logic               sgd_done = 1'b0;
  logic [ADDR_W-1:0]  sgd_addr = '0;
  logic ser_rst, ram_rst, sgd_rst, ram_we, ram_oe, sgd_hold, busy, done, error;
  logic [ADDR_W-1:0]  ram_addr, wr_cnt;
  logic [1:0]         err_code;
  logic [2:0]         state;
  logic [7:0]         run_cnt;

  always #5 CLK = ~CLK;

  sgd_seq_ctrl #(.ADDR_W(ADDR_W), .FEAT_W(FEAT_W), .EPOCH_W(EPOCH_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .data_points(data_points), .feat(feat), .epoch(epoch),
    .ser_flag(ser_flag), .ser_done(ser_done), .ser_addr(ser_addr),
    .sgd_done(sgd_done), .sgd_addr(sgd_addr),
    .ser_rst(ser_rst), .ram_rst(ram_rst), .sgd_rst(sgd_rst),
    .ram_we(ram_we), .ram_oe(ram_oe), .sgd_hold(sgd_hold), .ram_addr(ram_addr),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .state(state), .wr_cnt(wr_cnt), .run_cnt(run_cnt)
  );

  localparam int F_STATE = 0;
  localparam int F_SERR  = 1;
  localparam int F_RAMR  = 2;
  localparam int F_SGDR  = 3;
  localparam int F_OE    = 4;
  localparam int F_HOLD  = 5;
  localparam int F_BUSY  = 6;
  localparam int F_DONE  = 7;
  localparam int F_ERR   = 8;
  localparam int F_WE    = 9;
  localparam int F_CODE  = 10;
  localparam int F_WR    = 11;
  localparam int F_RUN   = 12;
  localparam int F_ADDR  = 13;

  typedef struct {
    int cyc;
    int fld;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string fname(input int f);
    case (f)
      F_STATE: return "state";
      F_SERR:  return "ser_rst";
      F_RAMR:  return "ram_rst";
      F_SGDR:  return "sgd_rst";
      F_OE:    return "ram_oe";
      F_HOLD:  return "sgd_hold";
      F_BUSY:  return "busy";
      F_DONE:  return "done";
      F_ERR:   return "error";
      F_WE:    return "ram_we";
      F_CODE:  return "err_code";
      F_WR:    return "wr_cnt";
      F_RUN:   return "run_cnt";
      default: return "ram_addr";
    endcase
  endfunction

  function automatic int actual(input int f);
    case (f)
      F_STATE: return int'(state);
      F_SERR:  return int'(ser_rst);
      F_RAMR:  return int'(ram_rst);
      F_SGDR:  return int'(sgd_rst);
      F_OE:    return int'(ram_oe);
      F_HOLD:  return int'(sgd_hold);
      F_BUSY:  return int'(busy);
      F_DONE:  return int'(done);
      F_ERR:   return int'(error);
      F_WE:    return int'(ram_we);
      F_CODE:  return int'(err_code);
      F_WR:    return int'(wr_cnt);
      F_RUN:   return int'(run_cnt);
      default: return int'(ram_addr);
    endcase
  endfunction

  // Monitor: every expectation due in this cycle is popped and compared mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.fld);
      n_chk++;
      if (e.cyc != cyc || a != e.val) begin
        n_fail++;
        $display("FAIL %s cycle=%0d (due %0d): got %0d, expected %0d", fname(e.fld), cyc, e.cyc, a, e.val);
      end
    end
  end

  task automatic ex(input int f, input int v);
    exp_t e;
    e.cyc = cyc;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected per-state control outputs; -1 marks a field left unchecked.
  task automatic ex_mode(input int st);
    int v[8];
    case (st)
      0:       v = '{1, 1, 1, 0, 0, 0, 0, 0};
      1:       v = '{1, 1, 1, 0, 0, 1, 0, 0};
      2:       v = '{0, 0, 1, 0, 0, 1, 0, 0};
      3:       v = '{-1, 0, 0, 1, 0, 1, 0, 0};
      4:       v = '{-1, 0, 0, 1, 1, 0, 1, 0};
      default: v = '{1, 0, 1, 0, 0, 0, 0, 1};
    endcase
    ex(F_STATE, st);
    for (int i = 0; i < 8; i++) if (v[i] >= 0) ex(F_SERR + i, v[i]);
    if (st != 2) ex(F_WE, 0);
    if (st == 0 || st == 1 || st == 5) ex(F_ADDR, 0);
  endtask

  // Issue start with a configuration and land in the PRIME cycle.
  task automatic start_prime(input int dp, input int f, input int e);
    data_points = ADDR_W'(dp);
    feat        = FEAT_W'(f);
    epoch       = EPOCH_W'(e);
    start       = 1'b1;
    step();
    start = 1'b0;
    ex_mode(1);
    ex(F_WR, 0);
    ex(F_CODE, 0);
  endtask

  // Present n valid words starting in the current LOAD cycle.
  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      ser_flag = 1'b0;
      ser_addr = ADDR_W'(12'h100 + i);
      ex_mode(2);
      ex(F_WE, 1);
      ex(F_ADDR, 12'h100 + i);
      ex(F_WR, i);
      step();
    end
    ser_flag = 1'b1;
  endtask

  // Complete run ending in the HOLD cycle.
  task automatic run_ok(input int dp, input int train_wait, input int exp_run);
    start_prime(dp, 3, 2);
    step();
    load_words(dp);
    ser_done = 1'b1;
    ex_mode(2);
    ex(F_WE, 0);
    ex(F_WR, dp);
    step();
    ser_done = 1'b0;
    sgd_addr = 12'h3A5;
    for (int i = 0; i < train_wait; i++) begin
      ex_mode(3);
      ex(F_ADDR, 12'h3A5);
      step();
    end
    sgd_done = 1'b1;
    ex_mode(3);
    ex(F_RUN, exp_run - 1);
    step();
    sgd_done = 1'b0;
    ex_mode(4);
    ex(F_RUN, exp_run);
    ex(F_WR, dp);
    ex(F_CODE, 0);
    ex(F_ADDR, 12'h3A5);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Reset values
    step();
    n_chk++;
    if (state != 3'd0) begin
      n_fail++;
      $display("FAIL state after reset: got %0d, expected 0", state);
    end
    n_chk++;
    if (wr_cnt != '0) begin
      n_fail++;
      $display("FAIL wr_cnt after reset: got %0d, expected 0", wr_cnt);
    end
    n_chk++;
    if (run_cnt != 8'd0) begin
      n_fail++;
      $display("FAIL run_cnt after reset: got %0d, expected 0", run_cnt);
    end
    n_chk++;
    if (err_code != 2'd0) begin
      n_fail++;
      $display("FAIL err_code after reset: got %0d, expected 0", err_code);
    end
    ex_mode(0);
    ex(F_CODE, 0);
    ex(F_WR, 0);
    ex(F_RUN, 0);
    RST = 1'b0;
    step();
    ex_mode(0);

    // Two clean runs: 4 rows, SGD done on the 20th TRAIN cycle, then a restart from HOLD
    run_ok(4, 19, 1);
    run_ok(4, 5, 2);

    // Short load: ser_done after 3 of 4 words
    start_prime(4, 3, 2);
    step();
    load_words(3);
    ser_done = 1'b1;
    ex_mode(2);
    ex(F_WE, 0);
    ex(F_WR, 3);
    step();
    ser_done = 1'b0;
    ex_mode(5);
    ex(F_CODE, 2);
    ex(F_WR, 3);

    // Zero epoch: PRIME then configuration fault
    start_prime(4, 3, 0);
    step();
    ex_mode(5);
    ex(F_CODE, 1);
    ex(F_WR, 0);
    ex(F_RUN, 2);

    // Overflow: a valid word after all rows are written
    start_prime(2, 3, 2);
    step();
    load_words(2);
    ser_flag = 1'b0;
    ser_addr = 12'h1FF;
    ex_mode(2);
    ex(F_WE, 0);
    ex(F_WR, 2);
    ex(F_ADDR, 12'h1FF);
    step();
    ser_flag = 1'b1;
    ex_mode(5);
    ex(F_CODE, 2);

    // Abort together with sgd_done in TRAIN; start ignored while training
    start_prime(2, 1, 1);
    step();
    load_words(2);
    ser_done = 1'b1;
    ex_mode(2);
    step();
    ser_done = 1'b0;
    sgd_addr = 12'h055;
    start = 1'b1;
    ex_mode(3);
    ex(F_ADDR, 12'h055);
    step();
    start = 1'b0;
    abort = 1'b1;
    sgd_done = 1'b1;
    ex_mode(3);
    step();
    abort = 1'b0;
    sgd_done = 1'b0;
    ex_mode(0);
    ex(F_RUN, 2);

    // Reset in the middle of LOAD clears everything, run count included
    start_prime(4, 3, 2);
    step();
    load_words(1);
    RST = 1'b1;
    ex_mode(2);
    ex(F_WR, 1);
    step();
    RST = 1'b0;
    ex_mode(0);
    ex(F_WR, 0);
    ex(F_RUN, 0);
    ex(F_CODE, 0);

    // No serial activity in LOAD
    start_prime(4, 3, 2);
    step();
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      ex_mode(2);
      ex(F_WR, 0);
      step();
    end
    ex_mode(5);
    ex(F_CODE, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    ex_mode(5);
    ex(F_CODE, 3);
`else
    for (int i = 0; i < 20; i++) begin
      ex_mode(2);
      ex(F_WR, 0);
      step();
    end
    ex_mode(2);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    ex_mode(0);
`endif

    step();
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s due cycle %0d: never compared, expected %0d", fname(e.fld), e.cyc, e.val);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
